// File: rtl/alu_result_reader.sv
// alu_result_reader: reads a base/count window of the result memory (mem_en/mem_addr/mem_dout) and streams it out on m_data/m_valid/m_ready via a 2-entry skid buffer, with start/busy/done control
module alu_result_reader #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);
  localparam int L = RD_LAT + 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W:0] rem;
  logic [L-1:0] pipe;
  logic [1:0] occ;
  logic [DATA_W-1:0] h1;
  logic [2:0] load;
  logic go, issue, capture, accept;
  assign load = 3'($countones(pipe)) + {1'b0, occ};
  assign go = state == IDLE && start && count != '0;
  assign issue = go || (state == READ && rem != '0 && load < 3'd2);
  assign capture = pipe[L-1];
  assign accept = m_valid && m_ready;
  assign mem_en = pipe[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (count == '0 ? DONE : READ) : IDLE;
      READ:    state_nxt = rem == '0 ? DRAIN : READ;
      DRAIN:   state_nxt = pipe == '0 && (occ == 2'd0 || (occ == 2'd1 && accept)) ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state == READ || state == DRAIN;
    done = state == DONE;
    m_valid = occ != 2'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      mem_addr <= '0;
      pipe <= '0;
      occ <= '0;
      m_data <= '0;
      h1 <= '0;
    end else begin
      rem <= go ? count - (ADDR_W+1)'(1) : issue ? rem - (ADDR_W+1)'(1) : rem;
      mem_addr <= go ? base_addr : issue ? mem_addr + ADDR_W'(1) : mem_addr;
      pipe <= {pipe[L-2:0], issue};
      occ <= occ + {1'b0, capture} - {1'b0, accept};
      if (capture && (accept ? occ == 2'd2 : occ != 2'd0)) h1 <= mem_dout;
      if (accept ? (occ == 2'd2 || capture) : (capture && occ == 2'd0))
        m_data <= accept && occ == 2'd2 ? h1 : mem_dout;
    end
endmodule

// File: tb/tb_alu_result_reader.sv
// tb_alu_result_reader: random readback windows and back-pressure on RD_LAT=1 and RD_LAT=2 lanes against a queue model
module tb_alu_result_reader;
  localparam int DW = 9;
  localparam int AW = 4;
  logic clk = 0, rst_n = 0, start = 0, m_ready = 1;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] count = '0;
  logic [DW-1:0] mem [16];
  logic mem_en [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_dout [2];
  logic [DW-1:0] m_data [2];
  logic m_valid [2], busy [2], done [2];
  bit done_seen [2];
  int n_vec = 0, n_err = 0, rmode = 0;
  always #5 clk = ~clk;
  task automatic chk(input int lane, input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL lane%0d %s got %0d want %0d", lane, tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;
    logic [DW-1:0] rd [LAT];
    logic [DW-1:0] q [$];
    logic [DW-1:0] held;
    int exp_addr, issued, accepted, cyc;
    bit active, due, first, stall;
    alu_result_reader #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
      .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_dout(mem_dout[g]),
      .m_data(m_data[g]), .m_valid(m_valid[g]), .m_ready(m_ready),
      .busy(busy[g]), .done(done[g]));
    always @(posedge clk) begin
      if (mem_en[g]) rd[0] <= mem[mem_addr[g]];
      for (int j = 1; j < LAT; j++) rd[j] <= rd[j-1];
    end
    assign mem_dout[g] = rd[LAT-1];
    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        active = 0;
        due = 0;
        first = 0;
        stall = 0;
      end else begin
        if (due || done[g]) begin
          chk(g, "done", done[g], due);
          if (done[g]) begin
            chk(g, "done_busy", busy[g], 0);
            chk(g, "done_left", q.size(), 0);
            done_seen[g] = 1;
            active = 0;
          end
        end
        due = 0;
        cyc++;
        if (active && !done[g]) chk(g, "busy", busy[g], 1);
        if (stall) begin
          chk(g, "hold_valid", m_valid[g], 1);
          chk(g, "hold_data", m_data[g], held);
        end
        if (mem_en[g]) begin
          chk(g, "addr", mem_addr[g], exp_addr);
          exp_addr = (exp_addr + 1) % 16;
          issued++;
          chk(g, "credit", issued - accepted <= 2, 1);
        end
        if (m_valid[g] && first) begin
          chk(g, "latency", cyc, LAT + 2);
          first = 0;
        end
        if (m_valid[g] && m_ready) begin
          if (q.size() == 0) chk(g, "extra_word", 1, 0);
          else begin
            chk(g, "data", m_data[g], q.pop_front());
            if (q.size() == 0) due = 1;
          end
          accepted++;
        end
        stall = m_valid[g] && !m_ready;
        held = m_data[g];
        if (start && !busy[g] && !done[g]) begin
          active = 1;
          first = 1;
          cyc = 0;
          exp_addr = base_addr;
          issued = 0;
          accepted = 0;
          for (int i = 0; i < count; i++) q.push_back(mem[(base_addr + i) % 16]);
          if (count == 0) due = 1;
        end
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk(k, {tag, "_en"}, mem_en[k], 0);
      chk(k, {tag, "_addr"}, mem_addr[k], 0);
      chk(k, {tag, "_valid"}, m_valid[k], 0);
      chk(k, {tag, "_data"}, m_data[k], 0);
      chk(k, {tag, "_busy"}, busy[k], 0);
      chk(k, {tag, "_done"}, done[k], 0);
    end
  endtask
  task automatic run(input int b, input int c, input bit spur);
    for (int i = 0; i < 200 && (busy[0] || busy[1] || done[0] || done[1]); i++) tick();
    done_seen = '{0, 0};
    start = 1;
    base_addr = AW'(b);
    count = (AW+1)'(c);
    tick();
    start = 0;
    if (spur && c >= 8) begin
      tick(3);
      start = 1;
      base_addr = AW'((b + 7) % 16);
      count = (AW+1)'(3);
      tick();
      start = 0;
    end
    for (int i = 0; i < 600 && !(done_seen[0] && done_seen[1]); i++) tick();
    chk(0, "finished", done_seen[0], 1);
    chk(1, "finished", done_seen[1], 1);
    tick(2);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i * 3);
    tick(2);
    check_zero("reset");
    rst_n = 1;
    tick(2);
    run(0, 4, 0);
    run(14, 4, 0);
    rmode = 1;
    run(0, 8, 0);
    run(3, 8, 0);
    run(0, 0, 0);
    run(5, 16, 0);
    run(2, 16, 1);
    rmode = 0;
    run(9, 16, 1);
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = DW'($urandom_range(0, 511));
      rmode = $urandom_range(0, 1);
      run($urandom_range(0, 15), $urandom_range(0, 16), 1'($urandom_range(0, 1)));
    end
    rmode = 2;
    start = 1;
    base_addr = AW'(0);
    count = (AW+1)'(16);
    tick();
    start = 0;
    tick(6);
    chk(0, "prefill", m_valid[0], 1);
    chk(1, "prefill", m_valid[1], 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1 check_zero("async_rst");
    tick(2);
    rst_n = 1;
    rmode = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        chk(k, "post_rst_valid", m_valid[k], 0);
        chk(k, "post_rst_done", done[k], 0);
      end
    end
    run(9, 5, 0);
    rmode = 0;
    run(15, 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
